// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for a two-digit multiplexed seven-segment scan.
// Debounces each digit slot, decodes the pattern, and reassembles {hi,lo}.
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sel_in,
  input  logic [7:0] seg_in,
  output logic [7:0] cnt_data,
  output logic       data_valid,
  output logic       digit_err,
  output logic       busy
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] STABLE  = CNT_W'(STABLE_CYCLES);
  localparam logic [3:0] SEL_LO   = 4'b1110;
  localparam logic [3:0] SEL_HI   = 4'b1101;
  localparam logic [3:0] SEL_NONE = 4'b1111;
  localparam logic [7:0] SEG_NONE = 8'hFF;

  typedef enum logic [1:0] {IDLE, HAVE_LO, HAVE_HI} state_t;

  logic [3:0]       sel_q, sel_prev, acc_sel;
  logic [7:0]       seg_q, seg_prev, acc_seg;
  logic [CNT_W-1:0] run, run_next;
  logic             same, acc, acc_next;

  state_t     state, state_next;
  logic [3:0] lo_q, hi_q, lo_next, hi_next;
  logic [7:0] cnt_next;
  logic       dv_next, err_next, busy_next;
  logic [4:0] dec;
  logic       slot_lo, slot_hi, dig_ok;

  // Segment pattern to {valid, nibble}; anything off-table is invalid.
  function automatic logic [4:0] decode_seg(input logic [7:0] pat);
    case (pat)
      8'h03:   decode_seg = {1'b1, 4'd0};
      8'h9F:   decode_seg = {1'b1, 4'd1};
      8'h25:   decode_seg = {1'b1, 4'd2};
      8'h0D:   decode_seg = {1'b1, 4'd3};
      8'h99:   decode_seg = {1'b1, 4'd4};
      8'h49:   decode_seg = {1'b1, 4'd5};
      8'h41:   decode_seg = {1'b1, 4'd6};
      8'h1F:   decode_seg = {1'b1, 4'd7};
      8'h01:   decode_seg = {1'b1, 4'd8};
      8'h09:   decode_seg = {1'b1, 4'd9};
      default: decode_seg = 5'b0_0000;
    endcase
  endfunction

  // run counts how many consecutive cycles the registered sample has held.
  always_comb begin
    same     = (sel_q == sel_prev) && (seg_q == seg_prev);
    run_next = CNT_W'(1);
    if (same) run_next = (run == CNT_MAX) ? run : run + CNT_W'(1);
    acc_next = (run_next == STABLE) && (!same || (run != STABLE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= SEL_NONE;
      seg_q    <= SEG_NONE;
      sel_prev <= SEL_NONE;
      seg_prev <= SEG_NONE;
      run      <= '0;
      acc      <= 1'b0;
      acc_sel  <= SEL_NONE;
      acc_seg  <= SEG_NONE;
    end else begin
      sel_q    <= sel_in;
      seg_q    <= seg_in;
      sel_prev <= sel_q;
      seg_prev <= seg_q;
      run      <= run_next;
      acc      <= acc_next;
      acc_sel  <= sel_q;
      acc_seg  <= seg_q;
    end
  end

  always_comb begin
    dec     = decode_seg(acc_seg);
    dig_ok  = dec[4];
    slot_lo = acc && (acc_sel == SEL_LO);
    slot_hi = acc && (acc_sel == SEL_HI);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (slot_lo || slot_hi) begin
      if (!dig_ok) begin
        state_next = IDLE;
      end else begin
        case (state)
          IDLE:    state_next = slot_lo ? HAVE_LO : HAVE_HI;
          HAVE_LO: state_next = slot_lo ? HAVE_LO : IDLE;
          HAVE_HI: state_next = slot_hi ? HAVE_HI : IDLE;
          default: state_next = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    cnt_next  = cnt_data;
    dv_next   = 1'b0;
    err_next  = 1'b0;
    lo_next   = lo_q;
    hi_next   = hi_q;
    busy_next = (state_next != IDLE);
    if (slot_lo || slot_hi) begin
      if (!dig_ok) begin
        err_next = 1'b1;
      end else if (slot_lo) begin
        lo_next = dec[3:0];
        if (state == HAVE_HI) begin
          cnt_next = {hi_q, dec[3:0]};
          dv_next  = 1'b1;
        end
      end else begin
        hi_next = dec[3:0];
        if (state == HAVE_LO) begin
          cnt_next = {dec[3:0], lo_q};
          dv_next  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_data   <= 8'h00;
      data_valid <= 1'b0;
      digit_err  <= 1'b0;
      busy       <= 1'b0;
      lo_q       <= 4'h0;
      hi_q       <= 4'h0;
    end else begin
      cnt_data   <= cnt_next;
      data_valid <= dv_next;
      digit_err  <= err_next;
      busy       <= busy_next;
      lo_q       <= lo_next;
      hi_q       <= hi_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: digit-level reference model predicts
// pulses, their arrival cycle, and the busy/cnt_data timeline.
module tb_seg_scan_decoder;

  localparam int unsigned S    = 4;
  localparam int          MAXC = 6000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sel_in = 4'hF;
  logic [7:0] seg_in = 8'hFF;
  logic [7:0] cnt_data;
  logic       data_valid, digit_err, busy;

  seg_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .sel_in(sel_in), .seg_in(seg_in),
    .cnt_data(cnt_data), .data_valid(data_valid),
    .digit_err(digit_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit err; logic [7:0] val; int t; } ev_t;
  ev_t q[$];

  logic [7:0] codes [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                             8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};
  bit         exp_busy [MAXC];
  logic [7:0] exp_cnt  [MAXC];

  bit         pend_lo = 0, pend_hi = 0, mon_on = 0;
  logic [3:0] lo_d = 0, hi_d = 0;
  logic [7:0] last_cnt = 8'h00;
  logic [11:0] prev_pins = 12'hFFF;
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int lookup(input logic [7:0] pat);
    for (int i = 0; i < 10; i++) if (codes[i] == pat) return i;
    return -1;
  endfunction

  task automatic fill(input int t);
    for (int i = t; i < MAXC; i++) begin
      exp_busy[i] = pend_lo | pend_hi;
      exp_cnt[i]  = last_cnt;
    end
  endtask

  // One accepted digit, visible on the outputs from cycle t onward.
  task automatic model_accept(input logic [3:0] sel, input logic [7:0] seg, input int t);
    int d;
    ev_t e;
    d = lookup(seg);
    e.t = t; e.err = 0; e.val = 8'h00;
    if (d < 0) begin
      e.err = 1; pend_lo = 0; pend_hi = 0; q.push_back(e);
    end else if (sel == 4'b1110) begin
      if (pend_hi) begin
        last_cnt = {hi_d, 4'(d)}; e.val = last_cnt; q.push_back(e);
        pend_hi = 0; pend_lo = 0;
      end else begin
        pend_lo = 1; lo_d = 4'(d);
      end
    end else begin
      if (pend_lo) begin
        last_cnt = {4'(d), lo_d}; e.val = last_cnt; q.push_back(e);
        pend_hi = 0; pend_lo = 0;
      end else begin
        pend_hi = 1; hi_d = 4'(d);
      end
    end
    fill(t);
  endtask

  // Present a pattern for len consecutive sampling edges.
  task automatic drive(input logic [3:0] sel, input logic [7:0] seg, input int len);
    int t0;
    @(negedge clk);
    sel_in = sel; seg_in = seg;
    t0 = cyc + 1;
    if (len >= int'(S) && (sel == 4'b1110 || sel == 4'b1101))
      model_accept(sel, seg, t0 + int'(S) + 1);
    prev_pins = {sel, seg};
    repeat (len - 1) @(negedge clk);
  endtask

  task automatic do_reset();
    drive(4'hF, 8'hFF, S + 2);
    @(negedge clk);
    rst = 1'b1;
    pend_lo = 0; pend_hi = 0; last_cnt = 8'h00;
    fill(cyc + 1);
    @(negedge clk);
    rst = 1'b0;
    prev_pins = 12'hFFF;
  endtask

  // Monitor: per-cycle busy/cnt_data timeline and pulse scoreboard.
  always @(negedge clk) begin
    if (mon_on && cyc < MAXC) begin
      chk("busy", busy, exp_busy[cyc]);
      chk("cnt_data", cnt_data, exp_cnt[cyc]);
      while (q.size() > 0 && q[0].t < cyc) begin
        n_chk++; n_fail++;
        $display("FAIL missed_pulse at cycle %0d: got none expected err=%0d val=%0h at %0d",
                 cyc, q[0].err, q[0].val, q[0].t);
        void'(q.pop_front());
      end
      if (data_valid || digit_err) begin
        if (q.size() == 0 || q[0].t != cyc) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_pulse at cycle %0d: got dv=%0b err=%0b expected none",
                   cyc, data_valid, digit_err);
        end else begin
          ev_t e;
          e = q.pop_front();
          chk("pulse_kind", {data_valid, digit_err}, {~e.err, e.err});
          if (!e.err) chk("pulse_value", cnt_data, e.val);
        end
      end
    end
  end

  initial begin
    logic [3:0] s;
    logic [7:0] g;
    int r, len;
    for (int i = 0; i < MAXC; i++) begin exp_busy[i] = 0; exp_cnt[i] = 8'h00; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_cnt_data", cnt_data, 8'h00);
    chk("reset_data_valid", data_valid, 0);
    chk("reset_digit_err", digit_err, 0);
    chk("reset_busy", busy, 0);
    mon_on = 1;

    drive(4'b1110, 8'h25, 6); drive(4'b1101, 8'h99, 6);
    for (int i = 0; i < 4; i++) begin drive(4'b1110, 8'h03, 3); drive(4'b1101, 8'h9F, 3); end
    drive(4'b1110, 8'hFF, 5); drive(4'b1101, 8'h03, 5); drive(4'b1110, 8'h1F, 5);
    drive(4'b1110, 8'h0D, 5); drive(4'b1110, 8'h01, 5); drive(4'b1101, 8'h09, 5);
    drive(4'b1110, 8'h49, 6); do_reset();
    drive(4'b1101, 8'h41, 5); drive(4'b1110, 8'h9F, 5);
    drive(4'b1011, 8'h03, 10);
    drive(4'b1110, 8'h99, S); drive(4'b1101, 8'h41, S - 1); drive(4'b1101, 8'h25, S);

    for (int n = 0; n < 220; n++) begin
      if ($urandom_range(0, 99) < 2) do_reset();
      do begin
        r = $urandom_range(0, 99);
        s = (r < 40) ? 4'b1110 : (r < 80) ? 4'b1101 : 4'($urandom);
        r = $urandom_range(0, 99);
        g = (r < 65) ? codes[$urandom_range(0, 9)] : (r < 85) ? 8'($urandom) : 8'hFF;
      end while ({s, g} == prev_pins);
      len = $urandom_range(1, 8);
      drive(s, g, len);
    end
    drive(4'hF, 8'hFF, S + 4);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #(MAXC * 10);
    $display("FAIL watchdog at cycle %0d: got timeout expected completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
